// File: rtl/window_pkg.sv
// window_pkg
// Shared constants, FSM state type and modular pointer arithmetic for the
// SPARC register-window controller (window_control) and its decoder.
package window_pkg;

  localparam int NWIN = 8;
  localparam int CWPW = $clog2(NWIN);

  localparam logic [7:0] TT_OVF = 8'h05;
  localparam logic [7:0] TT_UNF = 8'h06;

  typedef enum logic {
    IDLE      = 1'b0,
    TRAP_PEND = 1'b1
  } win_state_e;

  // Modulo-n increment: n-1 wraps to 0.
  function automatic int unsigned cwp_inc(input int unsigned c, input int unsigned n);
    return (c + 1 == n) ? 0 : c + 1;
  endfunction

  // Modulo-n decrement: 0 wraps to n-1.
  function automatic int unsigned cwp_dec(input int unsigned c, input int unsigned n);
    return (c == 0) ? n - 1 : c - 1;
  endfunction

endpackage

// File: rtl/window_control_if.sv
// window_control_if
// Bundles the decode/core/writeback-facing signals of window_control.
//   master : requester side (decode, core trap logic, writeback, testbench)
//   slave  : window_control itself
// Signals:
//   Save/Restore/TrapEntry/Rett : window requests
//   OpReady                     : Save/Restore/Rett accepted when high
//   WimWE/WimIn, Wim            : WIM load and current value
//   WE                          : register write strobe
//   Cwp, RE, WinWE              : window pointer, one-hot read enable, gated write enable
//   TrapReq/TrapType/TrapAck    : window trap request handshake
interface window_control_if #(
  parameter int NWIN = window_pkg::NWIN
);
  localparam int CW = $clog2(NWIN);

  logic            Save;
  logic            Restore;
  logic            TrapEntry;
  logic            Rett;
  logic            OpReady;
  logic            WimWE;
  logic [NWIN-1:0] WimIn;
  logic            WE;
  logic [NWIN-1:0] Wim;
  logic [CW-1:0]   Cwp;
  logic [NWIN-1:0] RE;
  logic [NWIN-1:0] WinWE;
  logic            TrapReq;
  logic [7:0]      TrapType;
  logic            TrapAck;

  modport master (
    output Save, Restore, TrapEntry, Rett, WimWE, WimIn, WE, TrapAck,
    input  OpReady, Wim, Cwp, RE, WinWE, TrapReq, TrapType
  );

  modport slave (
    input  Save, Restore, TrapEntry, Rett, WimWE, WimIn, WE, TrapAck,
    output OpReady, Wim, Cwp, RE, WinWE, TrapReq, TrapType
  );

endinterface

// File: rtl/window_decoder.sv
// window_decoder
// Purely combinational window select helpers.
//   i_cwp      : window pointer to decode
//   i_re       : registered one-hot read enable to gate
//   i_we       : register write strobe
//   o_onehot   : one-hot decode of i_cwp
//   o_win_we   : i_re gated by i_we (per-window write enable)
// The two halves are independent so the array's overlap logic can reuse
// the decode on neighbouring window pointers.
module window_decoder
  import window_pkg::*;
#(
  parameter int NWIN = window_pkg::NWIN,
  parameter int CW   = $clog2(NWIN)
) (
  input  logic [CW-1:0]   i_cwp,
  input  logic [NWIN-1:0] i_re,
  input  logic            i_we,
  output logic [NWIN-1:0] o_onehot,
  output logic [NWIN-1:0] o_win_we
);

  always_comb begin
    o_onehot        = '0;
    o_onehot[i_cwp] = 1'b1;
  end

  assign o_win_we = i_re & {NWIN{i_we}};

endmodule

// File: rtl/window_control.sv
// window_control
// Current-window-pointer / window-invalid-mask controller for the windowed
// register file. Decodes SAVE/RESTORE/trap entry/RETT into a registered CWP,
// drives one-hot read enable and per-window write enable, and raises
// overflow/underflow trap requests held until acknowledged.
// Ports:
//   Clk   : clock, all state on rising edge
//   Reset : synchronous active-high reset
//   bus   : window_control_if slave modport (requests, WIM, enables, trap handshake)
//
// state     | meaning
// IDLE      | accepting Save/Restore/Rett, OpReady=1
// TRAP_PEND | window trap raised, waiting for TrapAck, requests ignored
module window_control
  import window_pkg::*;
#(
  parameter int         NWIN   = window_pkg::NWIN,
  parameter logic [7:0] TT_OVF = window_pkg::TT_OVF,
  parameter logic [7:0] TT_UNF = window_pkg::TT_UNF
) (
  input  logic                   Clk,
  input  logic                   Reset,
  window_control_if.slave        bus
);

  localparam int CW = $clog2(NWIN);

  win_state_e      r_state;
  win_state_e      w_state_next;
  logic [CW-1:0]   r_cwp;
  logic [CW-1:0]   w_cwp_next;
  logic [NWIN-1:0] r_wim;
  logic [NWIN-1:0] r_re;
  logic [NWIN-1:0] w_re_next;
  logic [7:0]      r_tt;
  logic [7:0]      w_tt_next;
  logic [CW-1:0]   w_cwp_inc;
  logic [CW-1:0]   w_cwp_dec;
  logic [NWIN-1:0] w_win_we;

  assign w_cwp_inc = CW'(cwp_inc(32'(r_cwp), NWIN));
  assign w_cwp_dec = CW'(cwp_dec(32'(r_cwp), NWIN));

  // Next-state / next-pointer logic. Window checks always use the current
  // (old) Wim, so a WimWE in the same cycle does not affect them.
  always_comb begin
    w_state_next = r_state;
    w_cwp_next   = r_cwp;
    w_tt_next    = r_tt;
    case (r_state)
      IDLE: begin
        if (bus.TrapEntry) begin
          w_cwp_next = w_cwp_dec;
        end else if (bus.Save) begin
          if (r_wim[w_cwp_dec]) begin
            w_state_next = TRAP_PEND;
            w_tt_next    = TT_OVF;
          end else begin
            w_cwp_next = w_cwp_dec;
          end
        end else if (bus.Restore || bus.Rett) begin
          if (r_wim[w_cwp_inc]) begin
            w_state_next = TRAP_PEND;
            w_tt_next    = TT_UNF;
          end else begin
            w_cwp_next = w_cwp_inc;
          end
        end
      end
      TRAP_PEND: begin
        // Trap entry still moves the window while a trap is pending; it may
        // coincide with the acknowledge.
        if (bus.TrapEntry) begin
          w_cwp_next = w_cwp_dec;
        end
        if (bus.TrapAck) begin
          w_state_next = IDLE;
          w_tt_next    = 8'h00;
        end
      end
      default: begin
        w_state_next = IDLE;
        w_tt_next    = 8'h00;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= IDLE;
      r_cwp   <= '0;
      r_re    <= NWIN'(1);
      r_wim   <= '0;
      r_tt    <= 8'h00;
    end else begin
      r_state <= w_state_next;
      r_cwp   <= w_cwp_next;
      r_re    <= w_re_next;
      r_tt    <= w_tt_next;
      if (bus.WimWE) begin
        r_wim <= bus.WimIn;
      end
    end
  end

  // RE is registered from the decode of the next pointer so that it lines up
  // with Cwp; WinWE gates the registered RE and is the only combinational output.
  window_decoder #(
    .NWIN (NWIN),
    .CW   (CW)
  ) u_decoder (
    .i_cwp    (w_cwp_next),
    .i_re     (r_re),
    .i_we     (bus.WE),
    .o_onehot (w_re_next),
    .o_win_we (w_win_we)
  );

  assign bus.Cwp      = r_cwp;
  assign bus.RE       = r_re;
  assign bus.Wim      = r_wim;
  assign bus.WinWE    = w_win_we;
  assign bus.OpReady  = (r_state == IDLE);
  assign bus.TrapReq  = (r_state == TRAP_PEND);
  assign bus.TrapType = r_tt;

endmodule

// File: doc/window_control.md
# window_control

Current-window-pointer (CWP) and window-invalid-mask (WIM) controller for the SPARC windowed register file. It sits directly upstream of the register window array. It decodes SAVE/RESTORE/trap-entry/RETT requests from decode into a registered CWP. It drives the array's one-hot window read-enable and per-window write-enable vectors. It raises window overflow/underflow trap requests and holds them until the core acknowledges.

## Interface
Parameters:
- NWIN, 8, number of register windows; the CWP width is clog2(NWIN).
- TT_OVF, 8'h05, trap type for window_overflow.
- TT_UNF, 8'h06, trap type for window_underflow.

Ports:
- Clk  in  1  clock; all state updates on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- Save  in  1  SAVE request; CWP decrements.
- Restore  in  1  RESTORE request; CWP increments.
- TrapEntry  in  1  trap entry; CWP decrements with no WIM check.
- Rett  in  1  RETT; CWP increments with WIM check.
- OpReady  out  1  high when Save/Restore/Rett are accepted.
- WimWE  in  1  write enable for the WIM register.
- WimIn  in  NWIN  new WIM value.
- WE  in  1  register write strobe from writeback.
- Wim  out  NWIN  current WIM.
- Cwp  out  clog2(NWIN)  current window pointer.
- RE  out  NWIN  one-hot read enable: bit Cwp set.
- WinWE  out  NWIN  RE gated by WE; combinational from the registered RE.
- TrapReq  out  1  pending window trap.
- TrapType  out  8  TT_OVF or TT_UNF while TrapReq is high, else 0.
- TrapAck  in  1  core accepts the pending trap.

## Operation
- Cwp arithmetic is modulo NWIN. Decrement from 0 gives NWIN-1. Increment from NWIN-1 gives 0.
- New-pointer checks:
  - Save: Cwp-1.
  - Restore and Rett: Cwp+1.
  - If Wim bit at the new pointer is set, Cwp is unchanged and the FSM enters TRAP_PEND. Save sets TrapType=TT_OVF. Restore/Rett set TrapType=TT_UNF.
  - Otherwise Cwp updates to the new pointer.
- TrapEntry always decrements Cwp, including in TRAP_PEND, and never traps.
- Priority within one cycle: TrapEntry > Save > Restore > Rett. Lower-priority requests in the same cycle are dropped.
- FSM states:
  - IDLE: OpReady=1, TrapReq=0.
  - TRAP_PEND: OpReady=0, TrapReq=1. Save/Restore/Rett are ignored.
  - TRAP_PEND to IDLE on TrapAck. TrapAck in IDLE is ignored.
- WIM write:
  - WimWE loads WimIn at the clock edge.
  - A Save/Restore/Rett in the same cycle is checked against the old Wim.
- Reset values: Cwp=0, RE=1 (bit 0), Wim=0, state IDLE, OpReady=1, TrapReq=0, TrapType=0, WinWE=0.
- Reset mid-operation: reset wins over all other inputs. A pending trap is discarded.

## Timing
- All outputs are registered except WinWE, which is RE & {NWIN{WE}} and combinational.
- Cwp and RE change one cycle after the accepting edge. WinWE for the new window is valid in that same cycle.
- TrapReq/TrapType assert in the cycle after the faulting request. They hold until the edge where TrapAck is sampled high, then deassert the following cycle.
- OpReady falls together with the TrapReq assertion. A request in the cycle OpReady is low has no effect and is not queued.
- TrapEntry together with TrapAck in TRAP_PEND: Cwp decrements and the state returns to IDLE in the same edge.

## Structure
- Shared package `window_pkg`:
  - NWIN and the CWP width constant.
  - TT_OVF and TT_UNF.
  - FSM state enum {IDLE, TRAP_PEND}.
  - Modular increment/decrement functions.
- One natural sub-module, `window_decoder`: combinational Cwp to one-hot RE, plus the WE gating. It is reusable by the array's out-to-in overlap logic.
- Everything else stays flat: Cwp register, Wim register, FSM.

## Test plan
- Reset then idle: Cwp=0, RE=8'h01, Wim=0, OpReady=1, TrapReq=0. WE=1 gives WinWE=8'h01.
- Save x1 from Cwp=0 with Wim=0: Cwp=7, RE=8'h80. Then Restore x1 gives Cwp=0.
- WimIn=8'h40, WimWE, then Save from Cwp=7:
  - Cwp stays 7; TrapReq=1, TrapType=8'h05, OpReady=0.
  - Restore while pending is ignored.
  - TrapAck returns to IDLE.
- Wim=8'h02, Restore from Cwp=0: TrapReq=1, TrapType=8'h06, Cwp=0. TrapEntry in the same cycle as TrapAck gives Cwp=7 and state IDLE.
- WimWE (WimIn=8'h80) and Save in the same cycle from Cwp=0 (old Wim=0): Cwp=7 with no trap; Wim=8'h80 afterwards.
- Reset asserted during TRAP_PEND: next cycle Cwp=0, TrapReq=0, Wim=0, OpReady=1.
